lsu_bus_adapter: RTL and testbench
==================================

# lsu_bus_adapter

Load/store unit sitting directly downstream of the control decoder in the single-cycle RISC-V core. It consumes the decoded memory controls (MemEna, MemRW, SWSel), the ALU result as address and rs2 as store data. It runs each access as a req/ack transaction on an external data bus and returns width-formatted load data to the writeback mux. While a transaction is outstanding it holds the core with Stall, so the single-cycle datapath tolerates multi-cycle memory.

## Interface
Parameters:
- TIMEOUT, 255: maximum WAIT cycles without bus_ack before the access is aborted; 8-bit counter.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- MemEna  in  1  access request for the current instruction.
- MemRW  in  2  00 load, 01 SB, 10 SH, 11 SW.
- SWSel  in  3  load format: 000 LBU, 001 LHU, 010 LW, 011 LB, 100 LH; 101–111 treated as LW.
- Addr  in  32  byte address (ALU result).
- WData  in  32  store data (rs2).
- Stall  out  1  combinational; high freezes PC/regfile writes.
- RData  out  32  registered, formatted load data.
- MemErr  out  1  registered one-cycle error pulse.
- bus_req  out  1  transaction request, held until ack.
- bus_we  out  1  1 = write.
- bus_addr  out  32  word-aligned address, {Addr[31:2],2'b00}.
- bus_wdata  out  32  lane-replicated store data.
- bus_be  out  4  byte enables.
- bus_ack  in  1  transaction complete, sampled while bus_req=1.
- bus_rdata  in  32  read word, valid with bus_ack.
- bus_err  in  1  bus error, valid with bus_ack.

## Operation
- States: IDLE, WAIT, DONE.
- IDLE: if MemEna=1, latch address, type, format, be and wdata. Then go to WAIT with bus_req=1. Otherwise stay.
- WAIT: bus_req, bus_we, bus_addr, bus_be and bus_wdata stay stable. Inputs from the core are ignored.
  - On bus_ack: go to DONE and drop bus_req.
  - If bus_err accompanies bus_ack: MemErr=1 and RData=0. Error wins over data.
  - If the cycle counter reaches TIMEOUT: go to DONE with MemErr=1, RData=0, and drop bus_req.
- DONE: RData/MemErr valid; Stall=0 so the core retires; next edge → IDLE, MemErr cleared.
- Stall = (IDLE & MemEna) | WAIT.
- Stores:
  - SB: be = 4'b0001 << Addr[1:0]; wdata = {4{WData[7:0]}}.
  - SH: be = 4'b0011 << {Addr[1],1'b0}; wdata = {2{WData[15:0]}}.
  - SW: be = 4'b1111; wdata = WData.
  - RData unchanged on stores.
- Loads:
  - be = 4'b1111.
  - Byte lane is selected by Addr[1:0]; half lane by Addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- bus_ack while in IDLE or DONE is ignored.

## Timing
- Reset (async, immediate): state IDLE, bus_req 0, bus_we 0, bus_addr 0, bus_wdata 0, bus_be 0, RData 0, MemErr 0, counter 0. Stall follows MemEna combinationally.
- Reset mid-WAIT: bus_req drops immediately; the transaction is abandoned and a late ack is ignored.
- Latency: ack in the first WAIT cycle → 3 cycles per access (IDLE, WAIT, DONE). Each extra wait cycle adds 1.
- Timeout: after TIMEOUT WAIT cycles with no ack, DONE follows on the next edge.
- Back-to-back accesses: DONE → IDLE → WAIT; no idle bus cycle beyond IDLE.

## Configuration
- LSU_MISALIGN_CHECK_EN defined: misaligned accesses are detected in IDLE. Misaligned means half with Addr[0]=1, or word with Addr[1:0]≠0.
  - The access is not issued: no bus_req.
  - Next edge goes directly to DONE with MemErr=1 and RData=0, giving 2-cycle latency.
- Undefined: no check. Ignored low bits: Addr[0] for halves, Addr[1:0] for words. Halves use lane Addr[1]; words are aligned. MemErr comes only from bus_err or timeout.

## Test plan
- LW at 0x100, bus_rdata=0xDEADBEEF, ack in first WAIT cycle → bus_addr=0x100, be=1111, Stall high 2 cycles, RData=0xDEADBEEF in DONE.
- LB at 0x103, rdata=0x80123456 → RData=0xFFFFFF80; repeat as LBU → RData=0x00000080.
- SH at 0x202, WData=0x0000ABCD, ack after 3 WAIT cycles → bus_we=1, be=1100, wdata=0xABCDABCD, 5 total cycles.
- No ack, TIMEOUT=4 → bus_req high 4 cycles then low, MemErr=1 for one cycle, RData=0; bus_err with ack → same error response.
- rst asserted mid-WAIT → bus_req=0 immediately, state IDLE; an ack one cycle later does not change RData.
- With LSU_MISALIGN_CHECK_EN: LW at 0x101 → no bus_req, MemErr=1 in the second cycle; without it → bus_addr=0x100, normal LW.

Source files
------------

// File: rtl/lsu_bus_adapter.sv
// lsu_bus_adapter: runs core loads/stores as req/ack bus transactions, stalling the core until done.
// Optional define LSU_MISALIGN_CHECK_EN: misaligned half/word accesses fault in IDLE without a bus request.
module lsu_bus_adapter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemEna,
    input  logic [1:0]  MemRW,
    input  logic [2:0]  SWSel,
    input  logic [31:0] Addr,
    input  logic [31:0] WData,
    output logic        Stall,
    output logic [31:0] RData,
    output logic        MemErr,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    input  logic        bus_err
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_q, req_d;
    logic             we_q, we_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       be_q, be_d;
    logic [2:0]       sel_q, sel_d;
    logic [1:0]       off_q, off_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;

    logic [3:0]       st_be;
    logic [31:0]      st_wdata;
    logic             misalign;

    // Extract the addressed lane from the read word and extend it to 32 bits.
    function automatic logic [31:0] fmt_load(input logic [2:0] sel, input logic [1:0] off,
                                             input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> {off, 3'b000});
        h = off[1] ? w[31:16] : w[15:0];
        case (sel)
            3'b000:  return {24'b0, b};
            3'b001:  return {16'b0, h};
            3'b011:  return {{24{b[7]}}, b};
            3'b100:  return {{16{h[15]}}, h};
            default: return w;
        endcase
    endfunction

    // Byte enables and lane-replicated write data; loads take the full word.
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = WData;
        case (MemRW)
            2'b01: begin
                st_be    = 4'b0001 << Addr[1:0];
                st_wdata = {4{WData[7:0]}};
            end
            2'b10: begin
                st_be    = 4'b0011 << {Addr[1], 1'b0};
                st_wdata = {2{WData[15:0]}};
            end
            default: ;
        endcase
    end

`ifdef LSU_MISALIGN_CHECK_EN
    logic is_half;
    logic is_word;
    assign is_half  = (MemRW == 2'b10) || ((MemRW == 2'b00) && ((SWSel == 3'b001) || (SWSel == 3'b100)));
    assign is_word  = (MemRW == 2'b11) || ((MemRW == 2'b00) && (SWSel == 3'b010 || SWSel[2:1] == 2'b11 || SWSel == 3'b101));
    assign misalign = (is_half && Addr[0]) || (is_word && (Addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            sel_q   <= '0;
            off_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            sel_q   <= sel_d;
            off_q   <= off_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        sel_d   = sel_q;
        off_d   = off_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (MemEna) begin
                    if (misalign) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else begin
                        state_d = WAIT;
                        req_d   = 1'b1;
                        cnt_d   = '0;
                        we_d    = (MemRW != 2'b00);
                        addr_d  = {Addr[31:2], 2'b00};
                        be_d    = st_be;
                        wdata_d = st_wdata;
                        sel_d   = SWSel;
                        off_d   = Addr[1:0];
                    end
                end
            end
            WAIT: begin
                // Ack takes priority over a timeout landing in the same cycle.
                if (bus_ack) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    if (bus_err) begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else if (!we_q) begin
                        rdata_d = fmt_load(sel_q, off_q, bus_rdata);
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign Stall     = ((state_q == IDLE) && MemEna) || (state_q == WAIT);
    assign RData     = rdata_q;
    assign MemErr    = err_q;
    assign bus_req   = req_q;
    assign bus_we    = we_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign bus_be    = be_q;

endmodule

// File: tb/tb_lsu_bus_adapter.sv
// tb_lsu_bus_adapter: randomized and directed accesses checked against a behavioural LSU model.
module tb_lsu_bus_adapter;

    localparam int unsigned TB_TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        MemEna = 1'b0;
    logic [1:0]  MemRW = '0;
    logic [2:0]  SWSel = '0;
    logic [31:0] Addr = '0;
    logic [31:0] WData = '0;
    logic        Stall;
    logic [31:0] RData;
    logic        MemErr;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic        bus_err = 1'b0;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] exp_rdata = '0;

    always #5 clk = ~clk;

    lsu_bus_adapter #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk(clk), .rst(rst), .MemEna(MemEna), .MemRW(MemRW), .SWSel(SWSel),
        .Addr(Addr), .WData(WData), .Stall(Stall), .RData(RData), .MemErr(MemErr),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_be(bus_be), .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err)
    );

    function automatic logic [31:0] model_load(input logic [2:0] sel, input logic [31:0] addr,
                                               input logic [31:0] rd);
        int unsigned lane, b, h;
        lane = 32'(addr[1:0]);
        b = (rd >> (8 * lane)) & 32'hFF;
        h = (rd >> (16 * (lane / 2))) & 32'hFFFF;
        case (sel)
            3'd0:    return b;
            3'd1:    return h;
            3'd3:    return (b >= 128) ? b - 256 : b;
            3'd4:    return (h >= 32768) ? h - 65536 : h;
            default: return rd;
        endcase
    endfunction

`ifdef LSU_MISALIGN_CHECK_EN
    function automatic int unsigned access_size(input logic [1:0] rw, input logic [2:0] sel);
        if (rw == 2'b01) return 1;
        if (rw == 2'b10) return 2;
        if (rw == 2'b11) return 4;
        if (sel == 3'd0 || sel == 3'd3) return 1;
        if (sel == 3'd1 || sel == 3'd4) return 2;
        return 4;
    endfunction
`endif

    // One full access starting in IDLE at a falling edge; ends back in IDLE at a falling edge.
    task automatic do_access(input string name, input logic [1:0] rw, input logic [2:0] sel,
                             input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                             input int ack_wait, input logic err);
        int unsigned lane;
        logic        mis;
        logic        exp_we;
        logic        exp_err;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [31:0] exp_new;
        logic [3:0]  exp_be;
        int          waited;
        logic        acked;
        lane = 32'(addr[1:0]);
`ifdef LSU_MISALIGN_CHECK_EN
        mis = (addr % access_size(rw, sel)) != 0;
`else
        mis = 1'b0;
`endif
        exp_we   = (rw != 2'b00);
        exp_addr = addr & 32'hFFFF_FFFC;
        case (rw)
            2'b01: begin
                exp_be    = 4'(1 << lane);
                exp_wdata = (wd & 32'hFF) * 32'h0101_0101;
            end
            2'b10: begin
                exp_be    = 4'(3 << (lane & 2));
                exp_wdata = (wd & 32'hFFFF) * 32'h0001_0001;
            end
            default: begin
                exp_be    = 4'hF;
                exp_wdata = wd;
            end
        endcase
        exp_err = 1'b1;
        exp_new = '0;
        if (!mis && ack_wait >= 0 && ack_wait < int'(TB_TIMEOUT) && !err) begin
            exp_err = 1'b0;
            exp_new = (rw == 2'b00) ? model_load(sel, addr, rd) : exp_rdata;
        end

        MemEna = 1'b1; MemRW = rw; SWSel = sel; Addr = addr; WData = wd;
        bus_ack = 1'b0; bus_err = 1'b0;
        #1;
        n_cmp++;
        if (Stall !== 1'b1) begin
            n_fail++;
            $display("FAIL %s idle_stall: got %b want 1", name, Stall);
        end
        @(negedge clk);
        MemEna = 1'($urandom); MemRW = 2'($urandom); SWSel = 3'($urandom);
        Addr = $urandom; WData = $urandom;
        waited = 0;
        acked = 1'b0;
        if (!mis) begin
            while (!acked && waited < int'(TB_TIMEOUT)) begin
                n_cmp++;
                if (bus_req !== 1'b1 || Stall !== 1'b1 || bus_we !== exp_we || bus_addr !== exp_addr ||
                    bus_be !== exp_be || (exp_we && bus_wdata !== exp_wdata) || RData !== exp_rdata) begin
                    n_fail++;
                    $display("FAIL %s wait%0d: got req=%b stall=%b we=%b addr=%h be=%b wd=%h rd=%h want req=1 stall=1 we=%b addr=%h be=%b wd=%h rd=%h",
                             name, waited, bus_req, Stall, bus_we, bus_addr, bus_be, bus_wdata, RData,
                             exp_we, exp_addr, exp_be, exp_wdata, exp_rdata);
                end
                if (waited == ack_wait) begin
                    bus_ack = 1'b1; bus_rdata = rd; bus_err = err; acked = 1'b1;
                end else begin
                    bus_ack = 1'b0; bus_rdata = $urandom; bus_err = 1'($urandom);
                end
                @(negedge clk);
                waited++;
            end
            bus_ack = 1'b0;
            bus_err = 1'b0;
        end
        exp_rdata = exp_new;
        n_cmp++;
        if (bus_req !== 1'b0 || Stall !== 1'b0 || MemErr !== exp_err || RData !== exp_rdata) begin
            n_fail++;
            $display("FAIL %s done: got req=%b stall=%b err=%b rdata=%h want req=0 stall=0 err=%b rdata=%h",
                     name, bus_req, Stall, MemErr, RData, exp_err, exp_rdata);
        end
        @(negedge clk);
        n_cmp++;
        if (bus_req !== 1'b0 || MemErr !== 1'b0 || RData !== exp_rdata || Stall !== MemEna) begin
            n_fail++;
            $display("FAIL %s back_idle: got req=%b err=%b rdata=%h stall=%b want req=0 err=0 rdata=%h stall=%b",
                     name, bus_req, MemErr, RData, Stall, exp_rdata, MemEna);
        end
        MemEna = 1'b0;
    endtask

    task automatic test_reset();
        MemEna = 1'b0;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus_req, bus_we, bus_addr, bus_wdata, bus_be, RData, MemErr, Stall} !== '0) begin
            n_fail++;
            $display("FAIL reset_vals: got req=%b we=%b addr=%h wd=%h be=%b rd=%h err=%b stall=%b want all 0",
                     bus_req, bus_we, bus_addr, bus_wdata, bus_be, RData, MemErr, Stall);
        end
        MemEna = 1'b1;
        #1;
        n_cmp++;
        if (Stall !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_stall: got %b want 1", Stall);
        end
        MemEna = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_rdata = '0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        do_access("lw_100", 2'b00, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1'b0);
        n_cmp++;
        if (RData !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL lw_100_const: got %h want deadbeef", RData);
        end
        do_access("lb_103", 2'b00, 3'b011, 32'h103, 32'h0, 32'h80123456, 0, 1'b0);
        n_cmp++;
        if (RData !== 32'hFFFFFF80) begin
            n_fail++;
            $display("FAIL lb_103_const: got %h want ffffff80", RData);
        end
        do_access("lbu_103", 2'b00, 3'b000, 32'h103, 32'h0, 32'h80123456, 0, 1'b0);
        n_cmp++;
        if (RData !== 32'h00000080) begin
            n_fail++;
            $display("FAIL lbu_103_const: got %h want 00000080", RData);
        end
        do_access("sh_202", 2'b10, 3'b000, 32'h202, 32'h0000ABCD, 32'h0, 2, 1'b0);
        do_access("misalign_lw_101", 2'b00, 3'b010, 32'h101, 32'h0, 32'h11223344, 0, 1'b0);
    endtask

    task automatic test_lanes();
        for (int i = 0; i < 4; i++) begin
            do_access("sb_lane", 2'b01, 3'b000, 32'h400 + 32'(i), $urandom, $urandom, 0, 1'b0);
            do_access("lh_lane", 2'b00, 3'b100, 32'h500 + 32'(i), 32'h0, $urandom | 32'h8000_8000, 1, 1'b0);
            do_access("lhu_lane", 2'b00, 3'b001, 32'h500 + 32'(i), 32'h0, $urandom | 32'h8000_8000, 0, 1'b0);
        end
        for (int s = 0; s < 8; s++)
            do_access("load_sel", 2'b00, 3'(s), 32'h600 + 32'(s % 4), 32'h0, $urandom, 0, 1'b0);
        do_access("sw", 2'b11, 3'b000, 32'h700, 32'h12345678, 32'h0, 0, 1'b0);
    endtask

    task automatic test_timeout();
        do_access("lw_pre", 2'b00, 3'b010, 32'h800, 32'h0, 32'hA5A5A5A5, 0, 1'b0);
        do_access("timeout", 2'b00, 3'b010, 32'h804, 32'h0, 32'h0, -1, 1'b0);
        do_access("ack_last", 2'b00, 3'b010, 32'h808, 32'h0, 32'h5A5A5A5A, int'(TB_TIMEOUT) - 1, 1'b0);
        do_access("bus_err", 2'b00, 3'b010, 32'h80C, 32'h0, 32'hFFFFFFFF, 1, 1'b1);
        do_access("store_err", 2'b11, 3'b000, 32'h810, 32'h1, 32'h0, 0, 1'b1);
    endtask

    task automatic test_reset_mid_wait();
        do_access("lw_before_rst", 2'b00, 3'b010, 32'h900, 32'h0, 32'h13572468, 0, 1'b0);
        MemEna = 1'b1; MemRW = 2'b00; SWSel = 3'b010; Addr = 32'h904;
        @(negedge clk);
        MemEna = 1'b0;
        n_cmp++;
        if (bus_req !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_pre: got req=%b want 1", bus_req);
        end
        rst = 1'b1;
        #1;
        exp_rdata = '0;
        n_cmp++;
        if (bus_req !== 1'b0 || Stall !== 1'b0 || RData !== exp_rdata) begin
            n_fail++;
            $display("FAIL rst_mid_now: got req=%b stall=%b rd=%h want req=0 stall=0 rd=0", bus_req, Stall, RData);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        bus_ack = 1'b1; bus_rdata = 32'hCAFEF00D;
        @(negedge clk);
        bus_ack = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (RData !== exp_rdata || MemErr !== 1'b0 || bus_req !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_late_ack: got rd=%h err=%b req=%b want rd=0 err=0 req=0", RData, MemErr, bus_req);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 80; n++) begin
            do_access("random", 2'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
                      int'($urandom_range(0, 5)) - 1, ($urandom_range(0, 7) == 0));
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 4; n++)
            do_access("b2b", 2'($urandom), 3'b010, $urandom & 32'hFFFF_FFFC, $urandom, $urandom, 0, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_lanes();
        test_timeout();
        test_reset_mid_wait();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
